// File: rtl/pc_register_rstack_pkg.sv
// pc_register_rstack_pkg
//   Shared definitions for the program-counter / return-stack slice:
//   decoded operation codes (listed in priority order, CLR highest) and a
//   constant clog2 helper used to size the stack-count port.
package pc_register_rstack_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLR,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_INC,
    OP_DEC
  } pc_op_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/pc_register_rstack_return_stack.sv
// return_stack
//   DEPTH x W LIFO built from plain registers.
//   Ports:
//     clk_i, rst_ni     clock, async active-low reset (count only)
//     flush_i           empty the stack (highest priority)
//     push_i, pop_i     push push_data_i / drop top entry; ignored when full / empty
//     push_data_i       data to push
//     top_data_o        current top entry (don't-care when empty)
//     count_o           number of valid entries
//     full_o, empty_o   count_o == DEPTH / count_o == 0
module return_stack
  import pc_register_rstack_pkg::*;
#(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  push_data_i,
  output logic [W-1:0]  top_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Top entry lives at index count_q-1; searched so no out-of-range index.
  always_comb begin
    top_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_q) top_data_o = mem_q[i];
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i)                count_d = '0;
    else if (push_i && !full_o) count_d = count_q + 1'b1;
    else if (pop_i && !empty_o) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!flush_i && push_i && !full_o && (CW'(i) == count_q)) mem_q[i] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_register_rstack.sv
// pc_register_rstack
//   Program counter with load / inc / dec / clear and CALL/RET through a
//   return-address stack. One op per cycle, priority CLR>LOAD>CALL>RET>INC>DEC.
//   Ports:
//     CLK, RST_N        clock, async active-low reset
//     inpData           load / call target
//     LOAD INC DEC CLR CALL RET   operation strobes
//     opData            registered PC
//     stkCount          valid stack entries; stkFull / stkEmpty derived from it
//     stkOvf, stkUnf    sticky: CALL while full / RET while empty
module pc_register_rstack
  import pc_register_rstack_pkg::*;
#(
  parameter int unsigned    W         = 12,
  parameter int unsigned    STEP      = 1,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [W-1:0]   RESET_VAL = '0,
  localparam int unsigned   CW        = clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [W-1:0]  inpData,
  input  logic          LOAD,
  input  logic          INC,
  input  logic          DEC,
  input  logic          CLR,
  input  logic          CALL,
  input  logic          RET,
  output logic [W-1:0]  opData,
  output logic [CW-1:0] stkCount,
  output logic          stkFull,
  output logic          stkEmpty,
  output logic          stkOvf,
  output logic          stkUnf
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  pc_op_e       op;
  logic [W-1:0] pc_q, pc_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic         push, pop, flush;
  logic [W-1:0] top_data;

  always_comb begin
    op = OP_NONE;
    if      (CLR)  op = OP_CLR;
    else if (LOAD) op = OP_LOAD;
    else if (CALL) op = OP_CALL;
    else if (RET)  op = OP_RET;
    else if (INC)  op = OP_INC;
    else if (DEC)  op = OP_DEC;
  end

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    unique case (op)
      OP_CLR: begin
        pc_d  = RESET_VAL;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        flush = 1'b1;
      end
      OP_LOAD: pc_d = inpData;
      OP_CALL: begin
        if (!stkFull) begin
          push = 1'b1;
          pc_d = inpData;
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_RET: begin
        if (!stkEmpty) begin
          pop  = 1'b1;
          pc_d = top_data;
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_INC:  pc_d = pc_q + STEP_W;
      OP_DEC:  pc_d = pc_q - STEP_W;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VAL;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  return_stack #(
    .W    (W),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_stack (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .flush_i    (flush),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(pc_q + STEP_W),
    .top_data_o (top_data),
    .count_o    (stkCount),
    .full_o     (stkFull),
    .empty_o    (stkEmpty)
  );

  assign opData = pc_q;
  assign stkOvf = ovf_q;
  assign stkUnf = unf_q;

endmodule
